// File: rtl/haze_pkg.sv
// rtl/haze_pkg.sv - shared constants, divider states and byte helpers for haze_auto_levels
package haze_pkg;

  localparam int          PIX_W    = 8;
  localparam int          GAIN_W   = 16;
  localparam logic [15:0] GAIN_ONE = 16'd256;
  localparam logic [15:0] DIV_NUM  = 16'd65280;

  typedef enum logic [1:0] {IDLE, DIV, COMMIT} div_state_t;

  function automatic logic [PIX_W-1:0] min3(input logic [3*PIX_W-1:0] p);
    logic [PIX_W-1:0] m;
    m = p[7:0];
    if (p[15:8] < m) m = p[15:8];
    if (p[23:16] < m) m = p[23:16];
    return m;
  endfunction

  function automatic logic [PIX_W-1:0] max3(input logic [3*PIX_W-1:0] p);
    logic [PIX_W-1:0] m;
    m = p[7:0];
    if (p[15:8] > m) m = p[15:8];
    if (p[23:16] > m) m = p[23:16];
    return m;
  endfunction

  function automatic logic [PIX_W-1:0] sat8(input logic [23:0] v);
    return (|v[23:8]) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/seq_div_u16_u8.sv
// rtl/seq_div_u16_u8.sv - restoring divider, 16-bit numerator by 8-bit divisor, one quotient bit per cycle
module seq_div_u16_u8
  import haze_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [GAIN_W-1:0] num,
  input  logic [PIX_W-1:0]  den,
  output logic              busy,
  output logic              done,
  output logic [GAIN_W-1:0] quot
);

  logic [GAIN_W-1:0] num_r;
  logic [PIX_W-1:0]  den_r;
  logic [PIX_W-1:0]  rem;
  logic [3:0]        cnt;
  logic [PIX_W:0]    rem_sh;
  logic              ge;

  // done marks the cycle whose closing edge produces the last quotient bit
  assign rem_sh = {rem, num_r[GAIN_W-1]};
  assign ge     = (rem_sh >= {1'b0, den_r});
  assign done   = busy && (cnt == 4'd15);

  // start (re)loads operands and wins over abort; otherwise iterate while busy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num_r <= '0;
      den_r <= '0;
      rem   <= '0;
      quot  <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      num_r <= num;
      den_r <= den;
      rem   <= '0;
      quot  <= '0;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (abort) begin
      busy  <= 1'b0;
    end else if (busy) begin
      num_r <= {num_r[GAIN_W-2:0], 1'b0};
      rem   <= ge ? 8'(rem_sh - {1'b0, den_r}) : rem_sh[PIX_W-1:0];
      quot  <= {quot[GAIN_W-2:0], ge};
      cnt   <= cnt + 4'd1;
      if (cnt == 4'd15) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/haze_auto_levels.sv
// rtl/haze_auto_levels.sv - per-frame min/max auto-levels stretch applied to the following frame
module haze_auto_levels
  import haze_pkg::*;
#(
  parameter int MIN_RANGE = 32,
  parameter int GAIN_FRAC = 8
)
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pre_frame_vsync,
  input  logic                pre_frame_href,
  input  logic                pre_frame_clken,
  input  logic [3*PIX_W-1:0]  pre_img,
  output logic                post_frame_vsync,
  output logic                post_frame_href,
  output logic                post_frame_clken,
  output logic [3*PIX_W-1:0]  post_img,
  output logic [PIX_W-1:0]    coef_lo,
  output logic [GAIN_W-1:0]   coef_gain,
  output logic                coef_update
);

  logic              vsync_q, frame_edge, bypass, byp_q;
  logic [PIX_W-1:0]  pix_min, pix_max, run_min, run_max, lat_lo, range_c;
  div_state_t        state, state_nxt;
  logic              div_start, div_abort, div_busy, div_done, commit_en;
  logic [GAIN_W-1:0] div_quot;

  logic [2:0]              vs_d, hr_d, ck_d;
  logic [2:0][PIX_W-1:0]   d1;
  logic [GAIN_W-1:0]       g1;
  logic [2:0][23:0]        m2;
  logic [3*PIX_W-1:0]      img3;

  // the range decision uses the same values that are being latched on the edge
  assign frame_edge = pre_frame_vsync & ~vsync_q;
  assign pix_min    = min3(pre_img);
  assign pix_max    = max3(pre_img);
  assign range_c    = run_max - run_min;
  assign bypass     = (run_max < run_min) || (range_c < 8'(MIN_RANGE));

  // frame statistics; a pixel on the edge cycle seeds the new frame's accumulators
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      run_min <= 8'hFF;
      run_max <= 8'h00;
      lat_lo  <= 8'h00;
      byp_q   <= 1'b1;
    end else begin
      vsync_q <= pre_frame_vsync;
      if (frame_edge) begin
        lat_lo  <= run_min;
        byp_q   <= bypass;
        run_min <= pre_frame_clken ? pix_min : 8'hFF;
        run_max <= pre_frame_clken ? pix_max : 8'h00;
      end else if (pre_frame_clken) begin
        if (pix_min < run_min) run_min <= pix_min;
        if (pix_max > run_max) run_max <= pix_max;
      end
    end
  end

  seq_div_u16_u8 u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .abort (div_abort),
    .num   (DIV_NUM),
    .den   (range_c),
    .busy  (div_busy),
    .done  (div_done),
    .quot  (div_quot)
  );

  // divider state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // a frame edge always restarts the sequence, dropping any unfinished commit
  always_comb begin
    state_nxt = state;
    div_start = 1'b0;
    div_abort = 1'b0;
    commit_en = 1'b0;
    if (frame_edge) begin
      div_start = !bypass;
      div_abort = bypass && (state == DIV);
      state_nxt = bypass ? COMMIT : DIV;
    end else begin
      case (state)
        DIV: begin
          if (div_done)      state_nxt = COMMIT;
          else if (!div_busy) state_nxt = IDLE;
        end
        COMMIT: begin
          commit_en = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // coefficient registers, written only when leaving COMMIT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      coef_lo     <= 8'h00;
      coef_gain   <= GAIN_ONE;
      coef_update <= 1'b0;
    end else begin
      coef_update <= commit_en;
      if (commit_en) begin
        coef_lo   <= byp_q ? 8'h00 : lat_lo;
        coef_gain <= byp_q ? GAIN_ONE : div_quot;
      end
    end
  end

  // 3-stage stretch; the gain travels with the pixel so a commit never splits one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_d <= '0;
      hr_d <= '0;
      ck_d <= '0;
      d1   <= '0;
      g1   <= '0;
      m2   <= '0;
      img3 <= '0;
    end else begin
      vs_d <= {vs_d[1:0], pre_frame_vsync};
      hr_d <= {hr_d[1:0], pre_frame_href};
      ck_d <= {ck_d[1:0], pre_frame_clken};
      g1   <= coef_gain;
      for (int i = 0; i < 3; i++) begin
        d1[i] <= (pre_img[i*8 +: 8] > coef_lo) ? pre_img[i*8 +: 8] - coef_lo : 8'd0;
        m2[i] <= {16'd0, d1[i]} * {8'd0, g1};
        img3[i*8 +: 8] <= sat8(m2[i] >> GAIN_FRAC);
      end
    end
  end

  assign post_frame_vsync = vs_d[2];
  assign post_frame_href  = hr_d[2];
  assign post_frame_clken = ck_d[2];
  assign post_img         = img3;

endmodule
